// File: rtl/read_buffer_pkg.sv
// Framebuffer reader constants, fetch FSM states and
// small address helpers shared by the display read path.
package read_buffer_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_TOTAL  = 10'd525;
  localparam logic [6:0] WORDS    = 7'd80;
  localparam int         ADDR_W   = 18;
  localparam int         BUF_DEPTH = 160;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } rd_state_e;

  // y*80 as y*64 + y*16
  function automatic logic [ADDR_W-1:0] line_base(
    input logic [9:0] nv
  );
    logic [ADDR_W-1:0] n;
    n = ADDR_W'(nv);
    return (n << 6) + (n << 4);
  endfunction

  function automatic logic [7:0] buf_idx(
    input logic       bank,
    input logic [6:0] word
  );
    return (bank ? 8'd80 : 8'd0) + {1'b0, word};
  endfunction

endpackage

// File: rtl/read_buffer_if.sv
// SRAM read-port handshake between the line fetcher
// and the SRAM arbiter.
interface read_buffer_if;
  import read_buffer_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              ram_read;
  logic [15:0]       data_read;
  logic              ram_ready;

  modport master (
    output address,
    output ram_read,
    input  data_read,
    input  ram_ready
  );

  modport slave (
    input  address,
    input  ram_read,
    output data_read,
    output ram_ready
  );

endinterface

// File: rtl/read_buffer_line_ram.sv
// Ping-pong line store: 2 banks x 80 bytes, one write port
// for the fetcher and an asynchronous read port for display.
module read_buffer_line_ram
  import read_buffer_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/read_buffer.sv
// Fetches the next display line from SRAM into a ping-pong
// buffer and streams 1bpp pixels with one cycle of latency.
module read_buffer
  import read_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    hcount,
  input  logic [9:0]    vcount,
  read_buffer_if.master bus,
  output logic          pixel,
  output logic          underrun
);

  rd_state_e         state_q, state_d;
  logic [6:0]        word_q, word_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              issued_q, issued_d;
  logic [1:0]        valid_q;
  logic              underrun_q, underrun_d;
  logic              pixel_q;

  logic              ram_read;
  logic              wr_en;
  logic              set_valid;

  logic [10:0]       v_inc;
  logic              wrap;
  logic              fetch;
  logic [9:0]        nv;

  assign v_inc = {1'b0, vcount} + 11'd1;
  assign wrap  = vcount == V_TOTAL - 10'd1;
  assign fetch = (hcount == H_ACTIVE) &&
                 (wrap || v_inc < {1'b0, V_ACTIVE});
  assign nv    = wrap ? 10'd0 : v_inc[9:0];

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    issued_d   = 1'b0;
    underrun_d = underrun_q;
    ram_read   = 1'b0;
    wr_en      = 1'b0;
    set_valid  = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      // A falling ready only counts once ready was seen high
      // in REQ, so a stale read left over from an abort is
      // never mistaken for acceptance of this request.
      ST_REQ: begin
        ram_read = 1'b1;
        issued_d = issued_q | bus.ram_ready;
        if (issued_q && !bus.ram_ready) begin
          issued_d = 1'b0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.ram_ready) begin
          wr_en = 1'b1;
          if (word_q == WORDS - 7'd1) begin
            state_d = ST_DONE;
          end else begin
            word_d  = word_q + 7'd1;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_REQ;
          end
        end
      end
      ST_DONE: begin
        set_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fetch) begin
      if (state_q != ST_IDLE) underrun_d = 1'b1;
      bank_d    = nv[0];
      word_d    = 7'd0;
      addr_d    = line_base(nv);
      issued_d  = 1'b0;
      wr_en     = 1'b0;
      set_valid = 1'b0;
      state_d   = ST_REQ;
    end
  end

  logic       active;
  logic [6:0] rd_word;
  logic [7:0] rdata;

  assign active  = hcount < H_ACTIVE && vcount < V_ACTIVE;
  assign rd_word = active ? hcount[9:3] : 7'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word_q     <= 7'd0;
      bank_q     <= 1'b0;
      addr_q     <= '0;
      issued_q   <= 1'b0;
      valid_q    <= 2'b00;
      underrun_q <= 1'b0;
      pixel_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      underrun_q <= underrun_d;
      if (fetch) valid_q[nv[0]] <= 1'b0;
      else if (set_valid) valid_q[bank_q] <= 1'b1;
      pixel_q <= (active && valid_q[vcount[0]]) ?
                 rdata[hcount[2:0]] : 1'b0;
    end
  end

  read_buffer_line_ram u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (buf_idx(bank_q, word_q)),
    .wdata (bus.data_read[7:0]),
    .raddr (buf_idx(vcount[0], rd_word)),
    .rdata (rdata)
  );

  logic unused_hi;
  assign unused_hi = ^bus.data_read[15:8];

  assign bus.address  = addr_q;
  assign bus.ram_read = ram_read;
  assign pixel        = pixel_q;
  assign underrun     = underrun_q;

endmodule
